// File: rtl/sync_fifo2.sv
// Two-entry in-order FIFO with registered head and valid.
// Supports same-cycle push and pop; a push while full without a pop is dropped.
module sync_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_r, head_s;
  logic [WIDTH-1:0] tail_r, tail_s;
  logic [1:0]       count_r, count_s;
  logic             valid_r, valid_s;

  // Next-state for head/tail storage and occupancy
  always_comb begin
    head_s  = head_r;
    tail_s  = tail_r;
    count_s = count_r;
    case ({push, pop})
      2'b10: begin
        if (count_r == 2'd0) begin
          head_s  = din;
          count_s = 2'd1;
        end else if (count_r == 2'd1) begin
          tail_s  = din;
          count_s = 2'd2;
        end else begin
          count_s = count_r;
        end
      end
      2'b01: begin
        head_s  = tail_r;
        count_s = count_r - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; the new word lands behind whatever remains
        if (count_r == 2'd2) begin
          head_s = tail_r;
          tail_s = din;
        end else begin
          head_s = din;
        end
      end
      default: begin
        count_s = count_r;
      end
    endcase
    valid_s = (count_s != 2'd0);
  end

  // Storage and occupancy registers
  always_ff @(posedge clock) begin
    if (reset) begin
      head_r  <= {WIDTH{1'b0}};
      tail_r  <= {WIDTH{1'b0}};
      count_r <= 2'd0;
      valid_r <= 1'b0;
    end else begin
      head_r  <= head_s;
      tail_r  <= tail_s;
      count_r <= count_s;
      valid_r <= valid_s;
    end
  end

  assign head  = head_r;
  assign valid = valid_r;
  assign count = count_r;

endmodule

// File: rtl/mem_read_stream.sv
// Address-in / data-out read stage: synchronous-read memory, one-cycle latency,
// two-entry output buffer with credit-based address back-pressure.
module mem_read_stream #(
  parameter int DEPTH      = 20,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  addr_valid,
  output logic                  addr_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err_oob
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  inflight_r;
  logic                  oob_r;
  logic                  err_oob_r;
  logic                  issue_s;
  logic                  pop_s;
  logic                  ready_s;
  logic                  rd_in_range_s;
  logic                  wr_in_range_s;
  logic [1:0]            fifo_count_s;
  logic [2:0]            occ_s;

  assign rd_in_range_s = ({1'b0, addr_in} < DEPTH_L);
  assign wr_in_range_s = ({1'b0, wr_addr} < DEPTH_L);
  assign pop_s         = out_valid & out_ready;
  assign issue_s       = addr_valid & ready_s;
  assign occ_s         = {1'b0, fifo_count_s} + {2'b00, inflight_r};

  // Credit check: a slot is free now, or the only full slot drains this cycle
  always_comb begin
    ready_s = 1'b0;
    if (reset) begin
      ready_s = 1'b0;
    end else if (occ_s < 3'd2) begin
      ready_s = 1'b1;
    end else if ((occ_s == 3'd2) && pop_s) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  // Memory array write port; contents are deliberately not reset
  always_ff @(posedge clock) begin
    if (wr_en && wr_in_range_s) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read port and in-flight tracking; non-blocking read gives read-first ordering
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_r  <= {DATA_WIDTH{1'b0}};
      inflight_r <= 1'b0;
      oob_r      <= 1'b0;
    end else begin
      inflight_r <= issue_s;
      oob_r      <= issue_s & ~rd_in_range_s;
      if (issue_s) begin
        rd_data_r <= rd_in_range_s ? mem_r[addr_in] : {DATA_WIDTH{1'b0}};
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

  // Sticky out-of-range flag, raised on the edge that pushes the zero word
  always_ff @(posedge clock) begin
    if (reset) begin
      err_oob_r <= 1'b0;
    end else if (inflight_r && oob_r) begin
      err_oob_r <= 1'b1;
    end else begin
      err_oob_r <= err_oob_r;
    end
  end

  sync_fifo2 #(
    .WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (inflight_r),
    .pop   (pop_s),
    .din   (rd_data_r),
    .head  (out_data),
    .valid (out_valid),
    .count (fifo_count_s)
  );

  assign addr_ready = ready_s;
  assign err_oob    = err_oob_r;

endmodule

// File: doc/mem_read_stream.md
Name: mem_read_stream

Overview:
- Consumer stage placed directly downstream of an enable-driven address counter.
- Takes one address per handshake, reads an internal synchronous-read memory with 1-cycle latency, and presents the data on a valid/ready output stream.
- A 2-entry output buffer absorbs the read latency, so back-pressure from the sink reaches the address source through addr_ready. addr_ready drives the counter's enable.

Parameters:
DEPTH, 20, number of memory words; valid addresses are 0..DEPTH-1
ADDR_WIDTH, 5, address width; must satisfy 2**ADDR_WIDTH >= DEPTH
DATA_WIDTH, 8, memory word width

Ports:
clock  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
wr_en  input  1  memory write strobe
wr_addr  input  ADDR_WIDTH  write address
wr_data  input  DATA_WIDTH  write data
addr_in  input  ADDR_WIDTH  read address from upstream counter
addr_valid  input  1  addr_in is valid this cycle
addr_ready  output  1  read request accepted this cycle (issue = addr_valid & addr_ready)
out_data  output  DATA_WIDTH  head-of-buffer data
out_valid  output  1  out_data valid
out_ready  input  1  sink accepts out_data (pop = out_valid & out_ready)
err_oob  output  1  sticky flag: an issued read had addr_in >= DEPTH

Behaviour:
- Reset is synchronous, active-high, and sampled on the clock edge. Reset clears:
  - buffer count to 0 and inflight to 0
  - out_valid to 0, out_data to 0, err_oob to 0
- Reset does not initialise memory contents. Reset mid-operation discards any in-flight read and all buffered data; none of it is emitted after reset.
- Occupancy: occ = count + inflight, where inflight is 1 if a read was issued on the previous cycle.
- addr_ready = (occ < 2) | (occ == 2 & pop). This includes a combinational path from out_ready and is required for 1 read/cycle throughput. addr_ready is held 0 while reset is high.
- Read latency: an address issued on edge N produces data that is written into the buffer at edge N+1. out_valid rises after edge N+1, so the earliest pop is in the cycle after that edge.
- Buffer: 2-entry FIFO, strictly in order.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - occ never exceeds 2.
  - Overflow is impossible by construction and is asserted in verification.
- out_data and out_valid come from the registered FIFO head. out_data holds its value while out_valid & !out_ready.
- Memory write timing: write at edge N. A read issued at edge N to the same address returns the old data (read-first). A read issued at edge N+1 returns the new data.
- Out-of-range read (addr_in >= DEPTH when issued):
  - the returned word is 0
  - err_oob is set at the same edge that pushes the 0 word
  - err_oob stays set until reset
- Write with wr_addr >= DEPTH is ignored. It does not affect err_oob.
- addr_valid while !addr_ready: the request is not taken, and upstream must hold addr_in. With the counter enabled only on addr_ready, this is automatic.
- out_ready held 0: after 2 issues addr_ready drops to 0, and stays 0 until a pop occurs.

Decomposition:
- Shared package: none needed. DEPTH, ADDR_WIDTH and DATA_WIDTH stay module parameters.
- One natural sub-module: sync_fifo2, a 2-entry FIFO with push, pop, head, count and same-cycle push+pop.
- The memory array and the inflight/credit logic stay in the top module.

Test Plan:
- Reset then preload mem[i] = i+100 for i = 0..19; stream addresses 0..19 with out_ready=1 -> outputs 100..119 in order, one per cycle after the first; first out_valid is 2 edges after the first issue; err_oob = 0.
- Same stream with out_ready held 0 -> exactly 2 issues (addresses 0 and 1), then addr_ready = 0. out_data holds 100 with out_valid = 1. Releasing out_ready -> 100, 101, 102... with no loss or duplication.
- Random out_ready (50%) over 200 reads with wrapping addresses 0..19 -> output sequence equals the issued address sequence mapped through memory; occ never exceeds 2.
- Write mem[5]=0xAA at edge N while issuing a read of addr 5 at edge N -> old value 105 returned; a read issued at N+1 -> returns 0xAA.
- Issue addr_in=25 -> out_data=0 and err_oob=1 at the push edge. A following read of addr 3 returns 103, and err_oob stays 1.
- Assert reset with inflight=1 and count=2 -> after the edge: out_valid=0, err_oob=0, addr_ready=1 once reset is low; no stale data is emitted.
